// File: rtl/modbus_rtu_pkg.sv
// rtl/modbus_rtu_pkg.sv - shared Modbus RTU timing constants, FSM encoding and helpers
package modbus_rtu_pkg;

    localparam int RTU_GAP_BITS  = 35;
    localparam int RTU_T15_BITS  = 15;
    localparam int MAX_FRAME_LEN = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_GAP,
        ST_SEND,
        ST_WAIT_DONE,
        ST_POST_GAP
    } tx_state_t;

    function automatic int calc_bps(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/modbus_gap_timer.sv
// rtl/modbus_gap_timer.sv - bit-time ticker plus saturating line-silence counter
module modbus_gap_timer #(
    parameter int BPS_PARAM = 10,
    parameter int GAP_BITS  = 35
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       clr,
    input  logic       run,
    output logic       bit_tick,
    output logic [5:0] silence_cnt,
    output logic       gap_ok
);

    localparam logic [15:0] BAUD_LAST = 16'(BPS_PARAM - 1);
    localparam logic [5:0]  GAP_SAT   = 6'(GAP_BITS);

    logic [15:0] r_baud_cnt;
    logic [5:0]  r_silence;

    assign bit_tick    = (r_baud_cnt == BAUD_LAST);
    assign silence_cnt = r_silence;
    assign gap_ok      = (r_silence == GAP_SAT);

    // Reset presets the silence count so a fresh line counts as already idle.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_baud_cnt <= '0;
            r_silence  <= GAP_SAT;
        end else if (clr) begin
            r_baud_cnt <= '0;
            r_silence  <= '0;
        end else begin
            r_baud_cnt <= bit_tick ? '0 : r_baud_cnt + 16'd1;
            if (bit_tick && run && !gap_ok) begin
                r_silence <= r_silence + 6'd1;
            end
        end
    end

endmodule

// File: rtl/modbus_tx_frame_ctrl.sv
// rtl/modbus_tx_frame_ctrl.sv - Modbus RTU transmit frame sequencer with 3.5T framing silence
module modbus_tx_frame_ctrl
    import modbus_rtu_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int GAP_BITS  = RTU_GAP_BITS
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       frame_start,
    input  logic [8:0] frame_len,
    output logic       byte_req,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int BPS_PARAM = calc_bps(CLK_FREQ, BAUD_RATE);

    tx_state_t  r_state, w_next_state;
    logic [8:0] r_remaining;
    logic [7:0] r_hold_data, r_tx_data;
    logic       r_hold_full, r_in_flight, r_done_seen, r_req_pulse, r_frame_err;
    logic       w_bit_tick, w_gap_ok, w_hold_avail, w_len_ok, w_accept;
    logic       w_load_tx, w_set_err;
    logic [5:0] w_unused_silence_cnt;

    modbus_gap_timer #(
        .BPS_PARAM (BPS_PARAM),
        .GAP_BITS  (GAP_BITS)
    ) u_gap_timer (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .clr         (tx_start | tx_done),
        .run         (~r_in_flight),
        .bit_tick    (w_bit_tick),
        .silence_cnt (w_unused_silence_cnt),
        .gap_ok      (w_gap_ok)
    );

    assign w_len_ok     = (frame_len != 9'd0) && (frame_len <= 9'(MAX_FRAME_LEN));
    assign w_accept     = (r_state == ST_IDLE) && frame_start && w_len_ok;
    assign w_hold_avail = r_hold_full | byte_valid;

    assign tx_start   = (r_state == ST_SEND);
    assign tx_data    = r_tx_data;
    assign byte_req   = r_req_pulse | ((r_state == ST_SEND) && (r_remaining > 9'd1));
    assign frame_busy = (r_state != ST_IDLE);
    assign frame_done = (r_state == ST_POST_GAP) && w_gap_ok;
    assign frame_err  = r_frame_err;

    // The baud counter restarts on tx_done, so the first bit_tick after it
    // marks one full bit time with no byte ready: the underrun deadline.
    always_comb begin
        w_next_state = r_state;
        w_load_tx    = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_PRE_GAP;
                end else if (frame_start) begin
                    w_set_err = 1'b1;
                end
            end
            ST_PRE_GAP: begin
                if (w_gap_ok && w_hold_avail) begin
                    w_next_state = ST_SEND;
                    w_load_tx    = 1'b1;
                end
            end
            ST_SEND: w_next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (tx_done && (r_remaining == 9'd0)) begin
                    w_next_state = ST_POST_GAP;
                end else if (r_done_seen && w_hold_avail) begin
                    w_next_state = ST_SEND;
                    w_load_tx    = 1'b1;
                end else if (r_done_seen && w_bit_tick) begin
                    w_next_state = ST_POST_GAP;
                    w_set_err    = 1'b1;
                end
            end
            ST_POST_GAP: begin
                if (w_gap_ok) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_hold_data <= '0;
            r_hold_full <= 1'b0;
            r_tx_data   <= '0;
            r_in_flight <= 1'b0;
            r_done_seen <= 1'b0;
            r_req_pulse <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_req_pulse <= w_accept;
            r_frame_err <= w_set_err;

            if (w_accept) begin
                r_remaining <= frame_len;
            end else if (r_state == ST_SEND) begin
                r_remaining <= r_remaining - 9'd1;
            end

            if (w_load_tx) begin
                r_tx_data   <= r_hold_full ? r_hold_data : byte_in;
                r_hold_full <= 1'b0;
            end else if (byte_valid && !r_hold_full &&
                         (r_state inside {ST_PRE_GAP, ST_SEND, ST_WAIT_DONE})) begin
                r_hold_data <= byte_in;
                r_hold_full <= 1'b1;
            end else if (r_state inside {ST_IDLE, ST_POST_GAP}) begin
                r_hold_full <= 1'b0;
            end

            if (tx_start) begin
                r_in_flight <= 1'b1;
            end else if (tx_done) begin
                r_in_flight <= 1'b0;
            end

            if (r_state != ST_WAIT_DONE) begin
                r_done_seen <= 1'b0;
            end else if (tx_done) begin
                r_done_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modbus_tx_frame_ctrl.sv
// tb/tb_modbus_tx_frame_ctrl.sv - self-checking bench for modbus_tx_frame_ctrl
module tb_modbus_tx_frame_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       frame_start = 1'b0;
    logic [8:0] frame_len = '0;
    logic       byte_req;
    logic [7:0] byte_in = '0;
    logic       byte_valid = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;
    logic       frame_busy;
    logic       frame_done;
    logic       frame_err;

    modbus_tx_frame_ctrl #(
        .CLK_FREQ  (1000),
        .BAUD_RATE (100),
        .GAP_BITS  (35)
    ) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .frame_start (frame_start),
        .frame_len   (frame_len),
        .byte_req    (byte_req),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    int         cyc = 0;
    int         ts_q[$];
    logic [7:0] td_q[$];
    int         err_q[$];
    int         done_q[$];
    int         req_q[$];
    int         fs_q[$];
    logic       busy_at_done = 1'b0;
    bit         busy_seen = 1'b0;
    int         uart_due = -1;
    bit         src_pend = 1'b0;
    int         src_pend_idx = 0;
    int         withhold = -1;
    bit         inject = 1'b0;
    logic [7:0] src_data [256];

    typedef struct {
        int len;
        int pat;
        int wh;
        bit b2b;
    } vec_t;
    vec_t tbl [7];

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endfunction

    function automatic void chk_win(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endfunction

    // Source and UART models plus event log, all on the falling edge.
    initial begin
        forever begin
            @(negedge clk_in);
            cyc++;
            byte_valid = 1'b0;
            tx_done    = 1'b0;
            if (src_pend) begin
                src_pend   = 1'b0;
                byte_valid = 1'b1;
                byte_in    = src_data[src_pend_idx];
            end else if (inject) begin
                inject     = 1'b0;
                byte_valid = 1'b1;
                byte_in    = 8'hEE;
            end
            if (cyc == uart_due) tx_done = 1'b1;

            if (frame_start) fs_q.push_back(cyc);
            if (frame_busy) busy_seen = 1'b1;
            if (tx_start) begin
                ts_q.push_back(cyc);
                td_q.push_back(tx_data);
                uart_due = cyc + 100;
            end
            if (byte_req) begin
                req_q.push_back(cyc);
                if (req_q.size() - 1 != withhold && req_q.size() <= 256) begin
                    src_pend     = 1'b1;
                    src_pend_idx = req_q.size() - 1;
                end
            end
            if (frame_err) err_q.push_back(cyc);
            if (frame_done) begin
                done_q.push_back(cyc);
                busy_at_done = frame_busy;
            end
            if (!rst_n_in) begin
                uart_due = -1;
                src_pend = 1'b0;
                inject   = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        ts_q.delete(); td_q.delete(); err_q.delete();
        done_q.delete(); req_q.delete(); fs_q.delete();
        busy_seen = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    // Reference: idle line, source answers 1 cycle after byte_req, UART takes
    // 100 cycles. First tx_start at start+3, then each one 2 cycles after the
    // previous tx_done; silence of 35 bit times (350 cycles) closes the frame.
    task automatic run_frame(input int len, input int pat, input int wh, input bit poke);
        bit legal, poked, injected;
        int n_exp, n_req, budget, k, s, t, last_done;
        legal = (len >= 1 && len <= 256);
        for (int i = 0; i < 256; i++) begin
            case (pat)
                0:       src_data[i] = (i == 0) ? 8'h01 : (i == 1) ? 8'h03 : 8'h00;
                1:       src_data[i] = 8'(i);
                default: src_data[i] = 8'($urandom);
            endcase
        end
        clear_logs();
        withhold    = wh;
        frame_start = 1'b1;
        frame_len   = 9'(len);
        next_cycle();
        frame_start = 1'b0;

        n_exp  = !legal ? 0 : (wh >= 0 ? wh : len);
        n_req  = !legal ? 0 : (wh >= 0 ? wh + 1 : len);
        budget = legal ? len * 110 + 800 : 10;
        k = 0; poked = 0; injected = 0;
        while (k < budget && !(legal && done_q.size() > 0)) begin
            if (wh >= 0 && err_q.size() > 0 && !injected) begin
                inject   = 1'b1;
                injected = 1'b1;
            end
            if (poke && !poked && n_exp > 0 && ts_q.size() == n_exp && cyc > ts_q[n_exp-1] + 200) begin
                frame_start = 1'b1;
                frame_len   = 9'd5;
                poked       = 1'b1;
            end else begin
                frame_start = 1'b0;
            end
            next_cycle();
            k++;
        end
        frame_start = 1'b0;

        s = (fs_q.size() > 0) ? fs_q[0] : -1000;
        chk("tx_start_count", ts_q.size(), n_exp);
        chk("byte_req_count", req_q.size(), n_req);
        t = s + 3;
        for (int i = 0; i < n_exp && i < ts_q.size(); i++) begin
            chk("tx_start_time", ts_q[i], t);
            chk("tx_data", int'(td_q[i]), int'(src_data[i]));
            t = t + 102;
        end
        last_done = s + 3 + 102 * (n_exp - 1) + 100;
        if (!legal) begin
            chk("illegal_err_count", err_q.size(), 1);
            if (err_q.size() > 0) chk("illegal_err_time", err_q[0], s + 1);
            chk("illegal_done_count", done_q.size(), 0);
            chk("illegal_busy_seen", int'(busy_seen), 0);
        end else begin
            chk("err_count", err_q.size(), (wh >= 0) ? 1 : 0);
            if (wh >= 0 && err_q.size() > 0) chk_win("underrun_err_time", err_q[0], last_done + 9, last_done + 11);
            chk("done_count", done_q.size(), 1);
            if (done_q.size() > 0) begin
                chk_win("done_time", done_q[0], last_done + 349, last_done + 351);
                chk("busy_at_done", int'(busy_at_done), 1);
            end
            chk("busy_after_done", int'(frame_busy), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{len: 3,   pat: 0, wh: -1, b2b: 1'b0};
        tbl[1] = '{len: 2,   pat: 2, wh: -1, b2b: 1'b1};
        tbl[2] = '{len: 4,   pat: 2, wh: 2,  b2b: 1'b0};
        tbl[3] = '{len: 0,   pat: 2, wh: -1, b2b: 1'b0};
        tbl[4] = '{len: 300, pat: 2, wh: -1, b2b: 1'b0};
        tbl[5] = '{len: 1,   pat: 2, wh: -1, b2b: 1'b0};
        tbl[6] = '{len: 256, pat: 1, wh: -1, b2b: 1'b0};

        rst_n_in = 1'b0;
        repeat (4) next_cycle();
        chk("reset_outputs", int'({tx_start, tx_data, byte_req, frame_busy, frame_done, frame_err}), 0);
        rst_n_in = 1'b1;
        next_cycle();

        for (int i = 0; i < 7; i++) begin
            if (!tbl[i].b2b) repeat (3) next_cycle();
            run_frame(tbl[i].len, tbl[i].pat, tbl[i].wh, tbl[i].b2b);
        end

        repeat (3) next_cycle();
        clear_logs();
        withhold = -1;
        for (int i = 0; i < 256; i++) src_data[i] = 8'($urandom);
        frame_start = 1'b1;
        frame_len   = 9'd5;
        next_cycle();
        frame_start = 1'b0;
        for (int k = 0; k < 1000 && ts_q.size() < 2; k++) next_cycle();
        chk("abort_prestarts", ts_q.size(), 2);
        repeat (20) next_cycle();
        rst_n_in = 1'b0;
        next_cycle();
        rst_n_in = 1'b1;
        chk("abort_outputs", int'({tx_start, tx_data, byte_req, frame_busy, frame_done, frame_err}), 0);
        chk("abort_err_count", err_q.size(), 0);
        chk("abort_done_count", done_q.size(), 0);
        run_frame(3, 0, -1, 1'b0);

        for (int r = 0; r < 5; r++) begin
            int len, wh;
            len = $urandom_range(1, 12);
            wh  = (len > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : -1;
            repeat ($urandom_range(1, 6)) next_cycle();
            run_frame(len, 2, wh, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
